// File: rtl/io_bus_master_pkg.sv
// Shared constants for the IO bus master: response status codes, RW encoding
// and the transaction FSM state type.
package io_bus_master_pkg;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_TIMEOUT = 2'd1,
        STATUS_FAULT   = 2'd2
    } status_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE,
        ST_RESPOND
    } state_e;

    // Timeout outranks a slave fault when both occur in one transaction.
    function automatic status_e resolve_status(input logic timed_out, input logic faulted);
        if (timed_out) return STATUS_TIMEOUT;
        if (faulted)   return STATUS_FAULT;
        return STATUS_OK;
    endfunction

endpackage

// File: rtl/IO_bus.sv
// Four-phase register bus between one master and one slave: the master strobes
// handshake_1, the slave acknowledges on handshake_2 and may flag nFault.
interface IO_bus;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic [7:0]  reg_address;
    logic        RW;
    logic        handshake_1;
    logic        register_address_valid;
    logic        handshake_2;
    logic        nFault;

    modport master (
        output data_out, reg_address, RW, handshake_1, register_address_valid,
        input  data_in, handshake_2, nFault
    );

    modport slave (
        input  data_out, reg_address, RW, handshake_1, register_address_valid,
        output data_in, handshake_2, nFault
    );
endinterface

// File: rtl/io_bus_master.sv
// Turns single upstream commands into one four-phase IO bus transaction each,
// with a per-edge timeout and slave fault reporting.
module io_bus_master
    import io_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SETUP_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_addr,
    input  logic        cmd_rw,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    IO_bus.master       bus
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             started;
    logic [7:0]       addr_q;
    logic             rw_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             fault_q;
    logic             timeout_q;
    logic             accept;
    logic             in_handshake;
    logic             timed_out;
    status_e          status;

    assign accept       = cmd_valid && cmd_ready;
    assign in_handshake = (state == ST_STROBE) || (state == ST_RELEASE);
    assign timed_out    = in_handshake && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign status       = resolve_status(timeout_q, fault_q);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: defaults first so every path assigns next_state and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:    if (accept) next_state = ST_SETUP;
            ST_SETUP:   if (cnt == CNT_W'(SETUP_CYCLES - 1)) next_state = ST_STROBE;
            ST_STROBE: begin
                if (timed_out)            next_state = ST_RESPOND;
                else if (bus.handshake_2) next_state = ST_RELEASE;
            end
            ST_RELEASE: if (timed_out || !bus.handshake_2) next_state = ST_RESPOND;
            ST_RESPOND: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Decoded straight from the state register so reset clears them asynchronously.
    always_comb begin
        cmd_ready  = started && (state == ST_IDLE);
        rsp_valid  = (state == ST_RESPOND);
        rsp_status = STATUS_OK;
        rsp_rdata  = '0;
        if (state == ST_RESPOND) begin
            rsp_status = status;
            if (status == STATUS_OK) rsp_rdata = rdata_q;
        end
    end

    assign bus.handshake_1            = (state == ST_STROBE);
    assign bus.register_address_valid = (state == ST_SETUP) || in_handshake;
    assign bus.reg_address            = addr_q;
    assign bus.RW                     = rw_q;
    assign bus.data_out               = wdata_q;

    // NOTE: all datapath registers are reset; the bus fields must read 0 during reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            started   <= 1'b0;
            addr_q    <= '0;
            rw_q      <= RW_WRITE;
            wdata_q   <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            started <= 1'b1;
            cnt     <= (next_state != state) ? '0 : cnt + 1'b1;
            if (accept) begin
                addr_q    <= cmd_addr;
                rw_q      <= cmd_rw;
                wdata_q   <= cmd_wdata;
                rdata_q   <= '0;
                fault_q   <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (in_handshake && !bus.nFault) fault_q <= 1'b1;
            if (timed_out) timeout_q <= 1'b1;
            if (state == ST_STROBE && bus.handshake_2 && !timed_out && rw_q == RW_READ)
                rdata_q <= bus.data_in;
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: a reactive slave model drives the IO bus,
// outputs are sampled on the falling clock edge.
module tb_io_bus_master;
    import io_bus_master_pkg::*;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic        cmd_rw;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;

    IO_bus bus_if ();

    io_bus_master #(
        .TIMEOUT_CYCLES(16),
        .SETUP_CYCLES  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_status(rsp_status),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;

    int          lat;
    int          hs1_cycles;
    bit          got_rsp;
    bit          ready_at_issue;
    logic [1:0]  got_status;
    logic [31:0] got_rdata;
    logic [7:0]  seen_addr;
    logic [31:0] seen_data;
    logic        seen_rw;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one command and play the slave: ack ack_delay cycles into STROBE,
    // or never when silent. Returns at the negedge where rsp_valid is seen.
    task automatic do_txn(input logic [7:0] addr, input logic rw, input logic [31:0] wdata,
                          input int ack_delay, input bit fault, input bit silent,
                          input logic [31:0] slave_data);
        int strobe_n;
        @(negedge clk);
        cmd_valid      = 1'b1;
        cmd_addr       = addr;
        cmd_rw         = rw;
        cmd_wdata      = wdata;
        ready_at_issue = cmd_ready;
        @(negedge clk);
        cmd_valid  = 1'b0;
        lat        = 1;
        strobe_n   = 0;
        hs1_cycles = 0;
        got_rsp    = 1'b0;
        while (!got_rsp && lat < 100) begin
            if (bus_if.handshake_1) begin
                seen_addr = bus_if.reg_address;
                seen_data = bus_if.data_out;
                seen_rw   = bus_if.RW;
                hs1_cycles++;
                if (!silent && strobe_n >= ack_delay) begin
                    bus_if.handshake_2 = 1'b1;
                    bus_if.data_in     = slave_data;
                    bus_if.nFault      = !fault;
                end
                strobe_n++;
            end else begin
                bus_if.handshake_2 = 1'b0;
                bus_if.data_in     = '0;
                bus_if.nFault      = 1'b1;
            end
            if (rsp_valid) begin
                got_rsp    = 1'b1;
                got_status = rsp_status;
                got_rdata  = rsp_rdata;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    initial begin
        int n;
        int pulses;
        int accepts;
        int rsp1_at;
        int acc2_at;
        bit rsp_seen;

        reset              = 1'b0;
        cmd_valid          = 1'b0;
        cmd_addr           = '0;
        cmd_rw             = RW_WRITE;
        cmd_wdata          = '0;
        bus_if.handshake_2 = 1'b0;
        bus_if.data_in     = '0;
        bus_if.nFault      = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_hs1", bus_if.handshake_1, 0);
        check("rst_rav", bus_if.register_address_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_status", rsp_status, 0);
        check("rst_rdata", rsp_rdata, 0);
        reset = 1'b1;
        #1 check("ready_before_first_clk", cmd_ready, 0);
        @(negedge clk);
        check("ready_after_first_clk", cmd_ready, 1);

        // Write, slave acks 3 cycles into STROBE
        do_txn(8'h12, RW_WRITE, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, 32'h0);
        check("wr_ready_at_issue", ready_at_issue, 1);
        check("wr_got_rsp", got_rsp, 1);
        check("wr_status", got_status, STATUS_OK);
        check("wr_rdata", got_rdata, 0);
        check("wr_bus_addr", seen_addr, 8'h12);
        check("wr_bus_data", seen_data, 32'hDEAD_BEEF);
        check("wr_bus_rw", seen_rw, RW_WRITE);
        check("wr_latency", lat, 7);
        check("wr_rav_respond", bus_if.register_address_valid, 0);
        check("wr_addr_hold_respond", bus_if.reg_address, 8'h12);

        // Read, zero-wait slave
        do_txn(8'h05, RW_READ, 32'h0, 0, 1'b0, 1'b0, 32'h0000_ABCD);
        check("rd_got_rsp", got_rsp, 1);
        check("rd_status", got_status, STATUS_OK);
        check("rd_rdata", got_rdata, 32'h0000_ABCD);
        check("rd_bus_addr", seen_addr, 8'h05);
        check("rd_bus_rw", seen_rw, RW_READ);
        check("rd_latency", lat, 4);

        // Silent slave -> timeout after 16 STROBE cycles
        do_txn(8'h77, RW_READ, 32'h0, 0, 1'b0, 1'b1, 32'h5555_5555);
        check("to_got_rsp", got_rsp, 1);
        check("to_status", got_status, STATUS_TIMEOUT);
        check("to_rdata", got_rdata, 0);
        check("to_hs1_cycles", hs1_cycles, 16);
        check("to_hs1_respond", bus_if.handshake_1, 0);
        check("to_latency", lat, 18);
        @(negedge clk);
        check("to_ready_next", cmd_ready, 1);

        // Fault during read ack
        do_txn(8'h21, RW_READ, 32'h0, 1, 1'b1, 1'b0, 32'h1234_5678);
        check("flt_got_rsp", got_rsp, 1);
        check("flt_status", got_status, STATUS_FAULT);
        check("flt_rdata", got_rdata, 0);
        check("flt_latency", lat, 5);

        // Reset pulse while in STROBE
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 8'h33;
        cmd_rw    = RW_WRITE;
        cmd_wdata = 32'h1234_5678;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!bus_if.handshake_1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_strobe", bus_if.handshake_1, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_hs1", bus_if.handshake_1, 0);
        check("mid_rav", bus_if.register_address_valid, 0);
        check("mid_rw", bus_if.RW, 0);
        check("mid_addr", bus_if.reg_address, 0);
        check("mid_data", bus_if.data_out, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_status", rsp_status, 0);
        check("mid_rdata", rsp_rdata, 0);
        check("mid_cmd_ready", cmd_ready, 0);
        rsp_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen = 1'b1;
        end
        reset = 1'b1;
        @(negedge clk);
        if (rsp_valid) rsp_seen = 1'b1;
        check("mid_no_rsp", rsp_seen, 0);
        do_txn(8'h05, RW_READ, 32'h0, 0, 1'b0, 1'b0, 32'h0BAD_F00D);
        check("post_rst_status", got_status, STATUS_OK);
        check("post_rst_rdata", got_rdata, 32'h0BAD_F00D);

        // Back-to-back with cmd_valid held high
        cmd_valid = 1'b1;
        cmd_addr  = 8'h40;
        cmd_rw    = RW_WRITE;
        cmd_wdata = 32'h0000_0001;
        pulses    = 0;
        accepts   = 0;
        rsp1_at   = -1;
        acc2_at   = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (accepts == 2) cmd_valid = 1'b0;
            else if (accepts == 1) cmd_addr = 8'h41;
            bus_if.handshake_2 = bus_if.handshake_1;
            if (rsp_valid) begin
                pulses++;
                if (pulses == 1) rsp1_at = i;
            end
            if (cmd_valid && cmd_ready) begin
                accepts++;
                if (accepts == 2) acc2_at = i;
            end
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_accepts", accepts, 2);
        check("b2b_rsp1_at", rsp1_at, 4);
        check("b2b_second_accept", acc2_at, rsp1_at + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles to wait for each handshake_2 edge.
REQ-002 The block SHALL have parameter SETUP_CYCLES, default 1, giving the cycles from driving address/RW/data_out to asserting handshake_1.
REQ-003 Port clk SHALL be an input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port cmd_valid SHALL be an input, 1 bit: an upstream command is present.
REQ-006 Port cmd_ready SHALL be an output, 1 bit: the block accepts a command this cycle.
REQ-007 Port cmd_addr SHALL be an input, 8 bits: target register address.
REQ-008 Port cmd_rw SHALL be an input, 1 bit: 1 = read, 0 = write.
REQ-009 Port cmd_wdata SHALL be an input, 32 bits: write data.
REQ-010 Port rsp_valid SHALL be an output, 1 bit: one-cycle pulse marking a completed transaction.
REQ-011 Port rsp_rdata SHALL be an output, 32 bits: read data, zero for writes and errors.
REQ-012 Port rsp_status SHALL be an output, 2 bits: OK=0, TIMEOUT=1, FAULT=2.
REQ-013 Port bus SHALL be an IO_bus interface, master modport: drives data_out, reg_address, RW, handshake_1 and register_address_valid; samples data_in, handshake_2 and nFault.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, STROBE, RELEASE, RESPOND.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command SHALL be captured when cmd_valid && cmd_ready, and IDLE SHALL then go to SETUP.
REQ-016 In SETUP, reg_address, RW and data_out SHALL hold the captured values and register_address_valid SHALL be 1 for SETUP_CYCLES cycles; the FSM SHALL then go to STROBE.
REQ-017 In STROBE, handshake_1 SHALL be 1.
REQ-018 In STROBE, on the first cycle handshake_2 is sampled as 1, a read SHALL latch data_in into rsp_rdata and the FSM SHALL go to RELEASE.
REQ-019 In RELEASE, handshake_1 SHALL be 0 and register_address_valid SHALL be held at 1.
REQ-020 In RELEASE, when handshake_2 is sampled as 0, the FSM SHALL go to RESPOND.
REQ-021 RESPOND SHALL last one cycle, pulse rsp_valid with the status, deassert register_address_valid and return to IDLE.
REQ-022 A timeout counter SHALL clear on entry to STROBE and RELEASE and increment every cycle in those states.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL drop handshake_1, go to RESPOND with status TIMEOUT and set rsp_rdata to 0.
REQ-024 If nFault is sampled 0 in STROBE or RELEASE, the transaction SHALL complete its handshake normally but report status FAULT, with rsp_rdata forced to 0.
REQ-025 If timeout and fault are both true, TIMEOUT SHALL take priority.
REQ-026 If handshake_2 is already 1 on entry to STROBE (stale slave), the block SHALL treat it as an acknowledge; the slave owns that rule.
REQ-027 Minimum transaction latency, from the acceptance cycle to the rsp_valid cycle, SHALL be SETUP_CYCLES+3 cycles.
REQ-028 Back-to-back commands SHALL be allowed: cmd_ready SHALL reassert the cycle after RESPOND.
REQ-029 data_out, reg_address and RW SHALL remain stable from SETUP through RESPOND.

Reset
REQ-030 While reset=0, the state SHALL be IDLE and handshake_1, register_address_valid, RW, rsp_valid, rsp_status, reg_address, data_out and rsp_rdata SHALL all be 0.
REQ-031 While reset=0, cmd_ready SHALL be 0 until the first clock after reset is released.
REQ-032 Reset asserted mid-transaction SHALL abort immediately with no rsp_valid; handshake_1 SHALL drop asynchronously.

Structure
REQ-033 The status enum, RW encoding constants and the FSM state typedef SHALL live in the shared global constants package.
REQ-034 The timeout counter SHALL be an inline register; no sub-module is required.

Verification
REQ-035 Write: addr=0x12, wdata=0xDEADBEEF, slave acks after 3 cycles -> bus carries both values with RW=0; rsp_valid with status OK and rdata 0.
REQ-036 Read: addr=0x05, slave returns 0x0000ABCD with handshake_2 -> rsp_rdata=0x0000ABCD, status OK, latency 4 cycles at zero wait.
REQ-037 Silent slave, TIMEOUT_CYCLES=16 -> handshake_1 drops after 16 cycles in STROBE; status TIMEOUT; cmd_ready returns next cycle.
REQ-038 Slave asserts nFault=0 during a read ack -> status FAULT, rsp_rdata=0, handshake completes.
REQ-039 Reset pulse while in STROBE -> all outputs 0 immediately, no rsp_valid; the next command completes OK.
REQ-040 Two commands with cmd_valid held high -> exactly two rsp_valid pulses; the second command is accepted the cycle after the first RESPOND.
